pix_unpack_framer: RTL
======================

PIX_UNPACK_FRAMER -- requirements
Module: pix_unpack_framer

Interface
REQ-001 SHALL have parameter MAX_W, default 1024: maximum frame width in pixels.
REQ-002 SHALL have parameter MAX_H, default 768: maximum frame height in pixels.
REQ-003 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports cfg_w and cfg_h, input, 16 each: frame width and height, sampled on start.
REQ-006 SHALL have port start, input, 1: single-cycle frame-start pulse.
REQ-007 SHALL have ports s_axis_tdata (in, 64), s_axis_tvalid (in, 1), s_axis_tready (out, 1) and s_axis_tlast (in, 1): DMA MM2S word stream, 8 packed pixels per word, byte 0 (bits 7:0) first.
REQ-008 SHALL have ports m_axis_tdata (out, 64), m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tlast (out, 1), m_axis_tuser (out, 1) and m_axis_tkeep (out, 8): one pixel per beat toward the FAST/NMS pipeline.
REQ-009 SHALL have ports busy, done, err_cfg and err_last, output, 1 each: status.

Function
REQ-010 States SHALL be IDLE and RUN.
REQ-011 In IDLE, start with 1<=cfg_w<=MAX_W and 1<=cfg_h<=MAX_H SHALL latch W/H, clear err_cfg and err_last, and enter RUN on the next cycle.
REQ-012 In IDLE, start with an out-of-range cfg_w or cfg_h SHALL set err_cfg (sticky) and remain IDLE.
REQ-013 start while in RUN SHALL be ignored.
REQ-014 Frame pixels SHALL be packed contiguously across rows (W*H bytes, no per-row padding); unused upper bytes of the final word SHALL be discarded.
REQ-015 The block SHALL hold one input word register with a 3-bit byte index.
REQ-016 s_axis_tready SHALL be 1 only in RUN, while input words remain for the frame, and when either the word register is empty or the last used byte of the word register is being accepted downstream in the current cycle.
REQ-017 m_axis_tvalid SHALL be asserted whenever the word register holds an unsent byte.
REQ-018 The first pixel SHALL appear one cycle after its word handshake.
REQ-019 Sustained throughput SHALL be 1 pixel per cycle with no bubble at word boundaries.
REQ-020 m_axis_tdata SHALL carry the pixel in [7:0] and zeros in [63:8], except on the first frame beat, which SHALL carry H in [23:8] and W in [39:24].
REQ-021 m_axis_tuser SHALL be 1 on the first frame beat only.
REQ-022 m_axis_tlast SHALL be 1 on column W-1 of every row; W=1 gives tlast on every beat.
REQ-023 m_axis_tkeep SHALL be constant 8'hFF.
REQ-024 Output signals SHALL remain stable while tvalid=1 and tready=0.
REQ-025 Column counter SHALL wrap 0..W-1 and increment the row counter; pixel counter SHALL count 0..W*H-1 with 20-bit width.
REQ-026 s_axis_tlast=1 on any word other than word ceil(W*H/8)-1 SHALL set err_last.
REQ-027 The final word arriving with s_axis_tlast=0 SHALL set err_last.
REQ-028 Processing SHALL continue regardless of err_last.
REQ-029 Handshake of the last pixel SHALL pulse done for 1 cycle and return the block to IDLE in the same edge.
REQ-030 busy SHALL equal (state==RUN).

Reset
REQ-031 rst_n=0 SHALL force IDLE and clear counters, word register and all outputs (tvalid, tready, tlast, tuser, tdata, busy, done, err_cfg, err_last) to 0; m_axis_tkeep stays 8'hFF.
REQ-032 Reset mid-frame SHALL abandon the frame without emitting further beats; the next start SHALL begin a clean frame.

Structure
REQ-033 Package fast_pkg SHALL hold the beat-field constants (PIX_LSB=0, H_LSB=8, W_LSB=24, field widths) shared with the FAST/NMS top.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 W=4, H=2 with one word 0x0807060504030201 -> 8 beats with pixels 1..8; beat 0 tdata=0x000000_0004_0002_01 with tuser=1; tlast on beats 3 and 7; done pulse; err_last=0.
REQ-036 W=3, H=3 with 2 words, tlast on word 1 -> 9 beats, tlast on beats 2, 5 and 8; bytes 1..7 of word 1 dropped; s_axis_tready=0 afterward.
REQ-037 W=16, H=4 with m_axis_tready random 50% and source idle gaps -> 64 beats in order, outputs stable during stall, 100% throughput when both sides are always ready.
REQ-038 W=8, H=2 with s_axis_tlast on word 0 -> err_last=1, all 16 beats still emitted, done pulses.
REQ-039 start with cfg_w=0, or cfg_w=1025 with MAX_W=1024 -> err_cfg=1, busy=0, no tready; start during RUN -> no effect.
REQ-040 rst_n=0 at pixel 5 of a W=8, H=2 frame, then a new start -> no stale beats, fresh frame with tuser on beat 0.

Source files
------------

// File: rtl/fast_pkg.sv
// Beat-field layout and shared types for the FAST/NMS front end.
// The pixel unpacker and the FAST/NMS top both decode beats with these constants.
package fast_pkg;
    localparam int PIX_LSB   = 0;
    localparam int PIX_W     = 8;
    localparam int H_LSB     = 8;
    localparam int H_W       = 16;
    localparam int W_LSB     = 24;
    localparam int W_W       = 16;
    localparam int PIX_CNT_W = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/pix_unpack_framer.sv
// Unpacks 8-pixel DMA words into a one-pixel-per-beat frame stream with
// SOF/EOL markers and a W/H header carried on the first beat.
module pix_unpack_framer
    import fast_pkg::*;
#(
    parameter int MAX_W = 1024,
    parameter int MAX_H = 768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_w,
    input  logic [15:0] cfg_h,
    input  logic        start,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [7:0]  m_axis_tkeep,
    output logic        busy,
    output logic        done,
    output logic        err_cfg,
    output logic        err_last
);
    localparam logic [15:0] MAX_W16 = 16'(MAX_W);
    localparam logic [15:0] MAX_H16 = 16'(MAX_H);
    localparam int          WCNT_W  = PIX_CNT_W - 3;

    state_t                state_q, state_d;
    logic [15:0]           w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic [PIX_CNT_W-1:0]  total_q, total_d, pix_q, pix_d, prod;
    logic [WCNT_W-1:0]     nwords_q, nwords_d, wcnt_q, wcnt_d;
    logic [63:0]           wreg_q, wreg_d;
    logic                  full_q, full_d;
    logic [2:0]            idx_q, idx_d;
    logic                  done_q, done_d, err_cfg_q, err_cfg_d, err_last_q, err_last_d;
    logic                  cfg_ok, beat, last_byte, frame_end, rdy, in_hs;
    logic [7:0]            cur_pix;

    assign prod      = PIX_CNT_W'(cfg_w) * PIX_CNT_W'(cfg_h);
    assign cur_pix   = wreg_q[{idx_q, 3'b000} +: 8];
    assign cfg_ok    = (cfg_w != 16'd0) && (cfg_w <= MAX_W16) &&
                       (cfg_h != 16'd0) && (cfg_h <= MAX_H16);
    assign beat      = full_q && m_axis_tready;
    // The final word of a frame may end before byte 7; its tail bytes are never sent.
    assign last_byte = (idx_q == 3'd7) || (pix_q == total_q - 1'b1);
    assign frame_end = (row_q == h_q - 16'd1) && (col_q == w_q - 16'd1);
    assign rdy       = (state_q == ST_RUN) && (wcnt_q != nwords_q) &&
                       (!full_q || (beat && last_byte));
    assign in_hs     = rdy && s_axis_tvalid;

    assign s_axis_tready = rdy;
    assign m_axis_tvalid = full_q;
    assign m_axis_tuser  = full_q && (pix_q == '0);
    assign m_axis_tlast  = full_q && (col_q == w_q - 16'd1);
    assign m_axis_tkeep  = 8'hFF;
    assign busy          = (state_q == ST_RUN);
    assign done          = done_q;
    assign err_cfg       = err_cfg_q;
    assign err_last      = err_last_q;

    always_comb begin
        m_axis_tdata = '0;
        if (full_q) begin
            m_axis_tdata[PIX_LSB +: PIX_W] = cur_pix;
            if (pix_q == '0) begin
                m_axis_tdata[H_LSB +: H_W] = h_q;
                m_axis_tdata[W_LSB +: W_W] = w_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        total_d    = total_q;
        nwords_d   = nwords_q;
        wcnt_d     = wcnt_q;
        wreg_d     = wreg_q;
        full_d     = full_q;
        idx_d      = idx_q;
        col_d      = col_q;
        row_d      = row_q;
        pix_d      = pix_q;
        done_d     = 1'b0;
        err_cfg_d  = err_cfg_q;
        err_last_d = err_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        w_d        = cfg_w;
                        h_d        = cfg_h;
                        total_d    = prod;
                        nwords_d   = WCNT_W'((prod + PIX_CNT_W'(7)) >> 3);
                        wcnt_d     = '0;
                        full_d     = 1'b0;
                        idx_d      = '0;
                        col_d      = '0;
                        row_d      = '0;
                        pix_d      = '0;
                        err_cfg_d  = 1'b0;
                        err_last_d = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (beat) begin
                    pix_d = pix_q + 1'b1;
                    idx_d = idx_q + 3'd1;
                    if (col_q == w_q - 16'd1) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (last_byte) full_d = 1'b0;
                    if (frame_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // A new word may land in the same cycle the previous word's last byte leaves.
                if (in_hs) begin
                    wreg_d = s_axis_tdata;
                    full_d = 1'b1;
                    idx_d  = '0;
                    wcnt_d = wcnt_q + 1'b1;
                    if (s_axis_tlast != (wcnt_q == nwords_q - 1'b1)) err_last_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            total_q    <= '0;
            nwords_q   <= '0;
            wcnt_q     <= '0;
            wreg_q     <= '0;
            full_q     <= 1'b0;
            idx_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_q      <= '0;
            done_q     <= 1'b0;
            err_cfg_q  <= 1'b0;
            err_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            total_q    <= total_d;
            nwords_q   <= nwords_d;
            wcnt_q     <= wcnt_d;
            wreg_q     <= wreg_d;
            full_q     <= full_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pix_q      <= pix_d;
            done_q     <= done_d;
            err_cfg_q  <= err_cfg_d;
            err_last_q <= err_last_d;
        end
    end
endmodule
